// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the Hack RAM-port arbiter.
//   - state_t : FSM state encoding (IDLE / ACCESS / DONE)
//   - cnt_t   : latency down-counter type (supports LATENCY 1..15)
//   - AW_DEF / DW_DEF : default address / data widths of the Hack RAM port
package mem_arbiter_pkg;

  localparam int AW_DEF = 15;
  localparam int DW_DEF = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick.
//   req_a, req_b : pending requests
//   last         : requester served most recently (0 = A, 1 = B)
//   grant_valid  : at least one request is pending
//   grant_sel    : chosen requester (0 = A, 1 = B); only meaningful with grant_valid
module rr_pick2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic grant_valid,
  output logic grant_sel
);

  always_comb begin
    grant_valid = req_a | req_b;
    // On a tie the requester that was not served last wins; otherwise the
    // lone requester wins (req_b alone selects B, req_a alone selects A).
    if (req_a && req_b) begin
      grant_sel = ~last;
    end else begin
      grant_sel = req_b;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter for the single shared Hack RAM port.
//   Requester A = CPU data port, requester B = screen/UART DMA engine.
//   clk, reset                         : clock, synchronous active-high reset
//   req_x, addr_x, we_x, wdata_x       : request + access attributes (x = a, b)
//   ack_x                              : one-cycle completion pulse
//   rdata                              : read data, valid while ack_a/ack_b is high
//   sel                                : RAM-port mux select (0 = A, 1 = B)
//   mem_addr, mem_we, mem_wdata        : RAM port command
//   mem_rdata                          : RAM read data, valid LATENCY cycles after mem_addr
//   dbg_state                          : current FSM state
//
// Handshake: a requester raises req_x with stable addr/we/wdata and holds all of
// them until it samples ack_x = 1, then drops req_x at that same edge. ack_x is
// high for exactly one cycle (DONE); the following cycle is always IDLE, so a
// dropped request is never re-granted. Requests that vanish in IDLE before
// being granted are simply not served. LATENCY must be in 1..15.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_a,
  input  logic [AW-1:0] addr_a,
  input  logic          we_a,
  input  logic [DW-1:0] wdata_a,
  output logic          ack_a,
  input  logic          req_b,
  input  logic [AW-1:0] addr_b,
  input  logic          we_b,
  input  logic [DW-1:0] wdata_b,
  output logic          ack_b,
  output logic [DW-1:0] rdata,
  output logic          sel,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output state_t        dbg_state
);

  state_t        state;
  state_t        state_nxt;
  cnt_t          cnt;
  logic          last;
  logic          sel_q;
  logic [DW-1:0] rdata_q;
  logic          grant_valid;
  logic          grant_sel;

  rr_pick2 u_pick (
    .req_a       (req_a),
    .req_b       (req_b),
    .last        (last),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (grant_valid) state_nxt = ST_ACCESS;
      ST_ACCESS: if (cnt == '0)   state_nxt = ST_DONE;
      ST_DONE:                    state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers. last resets to B so A wins the first tie. sel is only
  // reloaded on a grant, so it holds steady through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      last    <= 1'b1;
      sel_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            sel_q <= grant_sel;
            cnt   <= cnt_t'(LATENCY - 1);
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            rdata_q <= mem_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          last <= sel_q;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // Outputs decoded from registered state. Address and write data follow the
  // sel mux at all times; only the write strobe is qualified by ACCESS.
  always_comb begin
    ack_a     = (state == ST_DONE) && !sel_q;
    ack_b     = (state == ST_DONE) &&  sel_q;
    mem_we    = (state == ST_ACCESS) && (sel_q ? we_b : we_a);
    mem_addr  = sel_q ? addr_b  : addr_a;
    mem_wdata = sel_q ? wdata_b : wdata_a;
  end

  assign rdata     = rdata_q;
  assign sel       = sel_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives three arbiter instances (LATENCY = 1, 2, 3) that share
// clock and reset, each with its own RAM model. A transaction-level reference
// model predicts winner, timing, strobes and read data.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 15;
  localparam int DW = 16;
  localparam int NI = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [NI-1:0] req_a_v, we_a_v, req_b_v, we_b_v;
  logic [AW-1:0] addr_a_v [NI];
  logic [AW-1:0] addr_b_v [NI];
  logic [DW-1:0] wdata_a_v [NI];
  logic [DW-1:0] wdata_b_v [NI];
  logic [NI-1:0] ack_a_w, ack_b_w, sel_w, mem_we_w;
  logic [DW-1:0] rdata_w [NI];
  logic [DW-1:0] mem_wdata_w [NI];
  logic [DW-1:0] mem_rdata_w [NI];
  logic [AW-1:0] mem_addr_w [NI];
  state_t        st_w [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_arbiter #(.LATENCY(g + 1), .AW(AW), .DW(DW)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_a     (req_a_v[g]),
      .addr_a    (addr_a_v[g]),
      .we_a      (we_a_v[g]),
      .wdata_a   (wdata_a_v[g]),
      .ack_a     (ack_a_w[g]),
      .req_b     (req_b_v[g]),
      .addr_b    (addr_b_v[g]),
      .we_b      (we_b_v[g]),
      .wdata_b   (wdata_b_v[g]),
      .ack_b     (ack_b_w[g]),
      .rdata     (rdata_w[g]),
      .sel       (sel_w[g]),
      .mem_addr  (mem_addr_w[g]),
      .mem_we    (mem_we_w[g]),
      .mem_wdata (mem_wdata_w[g]),
      .mem_rdata (mem_rdata_w[g]),
      .dbg_state (st_w[g])
    );
  end

  // ---------------- RAM models + ack monitor ----------------
  logic [DW-1:0] ram [int];
  int unsigned n_ack_a [NI] = '{default: 0};
  int unsigned n_ack_b [NI] = '{default: 0};
  int unsigned ack_cyc [NI] = '{default: 0};

  function automatic int key_of(input int k, input logic [AW-1:0] a);
    int ai;
    ai = a;
    return k * 65536 + ai;
  endfunction

  function automatic logic [DW-1:0] init_val(input int k, input logic [AW-1:0] a);
    return {1'b0, a} ^ 16'hA5C3 ^ (16'(k) * 16'h1111);
  endfunction

  function automatic logic [DW-1:0] ram_rd(input int k, input logic [AW-1:0] a);
    int key;
    key = key_of(k, a);
    return ram.exists(key) ? ram[key] : init_val(k, a);
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (mem_we_w[k]) ram[key_of(k, mem_addr_w[k])] = mem_wdata_w[k];
      mem_rdata_w[k] = ram_rd(k, mem_addr_w[k]);
      if (ack_a_w[k]) begin n_ack_a[k]++; ack_cyc[k] = cyc; end
      if (ack_b_w[k]) begin n_ack_b[k]++; ack_cyc[k] = cyc; end
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [int];
  bit            last_srv [NI];   // 1 = B served most recently
  bit            exp_sel  [NI];

  function automatic logic [DW-1:0] ref_rd(input int k, input logic [AW-1:0] a);
    int key;
    key = key_of(k, a);
    return ref_mem.exists(key) ? ref_mem[key] : init_val(k, a);
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int k, input bit who);
    if (!who) begin
      req_a_v[k] = 1'b1; addr_a_v[k] = AW'($urandom_range(0, 'hFFF));
      we_a_v[k] = 1'($urandom_range(0, 1)); wdata_a_v[k] = DW'($urandom);
    end else begin
      req_b_v[k] = 1'b1; addr_b_v[k] = AW'($urandom_range(0, 'hFFF));
      we_b_v[k] = 1'($urandom_range(0, 1)); wdata_b_v[k] = DW'($urandom);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      req_a_v[k] = 1'b0; req_b_v[k] = 1'b0;
      last_srv[k] = 1'b1; exp_sel[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("i%0d rst state", k), st_w[k], ST_IDLE);
      chk($sformatf("i%0d rst ack_a", k), ack_a_w[k], 0);
      chk($sformatf("i%0d rst ack_b", k), ack_b_w[k], 0);
      chk($sformatf("i%0d rst mem_we", k), mem_we_w[k], 0);
      chk($sformatf("i%0d rst sel", k), sel_w[k], 0);
      chk($sformatf("i%0d rst rdata", k), rdata_w[k], 0);
    end
    reset = 1'b0;
  endtask

  task automatic idle_check(input int k);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("i%0d idle state", k), st_w[k], ST_IDLE);
    chk($sformatf("i%0d idle ack", k), {ack_a_w[k], ack_b_w[k]}, 0);
    chk($sformatf("i%0d idle mem_we", k), mem_we_w[k], 0);
    chk($sformatf("i%0d idle sel", k), sel_w[k], exp_sel[k]);
  endtask

  // Called in the IDLE cycle where the requests are already presented.
  // Checks the whole transaction and the following IDLE cycle.
  task automatic serve(input int k, input bit keep);
    int            lat;
    bit            w;
    logic [AW-1:0] ea;
    logic          ewe;
    logic [DW-1:0] ed, er;
    string         t;
    lat = k + 1;
    if (req_a_v[k] && req_b_v[k]) w = !last_srv[k];
    else                          w = req_b_v[k];
    ea  = w ? addr_b_v[k]  : addr_a_v[k];
    ewe = w ? we_b_v[k]    : we_a_v[k];
    ed  = w ? wdata_b_v[k] : wdata_a_v[k];
    er  = ref_rd(k, ea);
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk);
      @(negedge clk);
      t = $sformatf("i%0d t%0d c%0d", k, cyc, c);
      if (c <= lat) begin
        chk({t, " state"}, st_w[k], ST_ACCESS);
        chk({t, " sel"}, sel_w[k], w);
        chk({t, " mem_addr"}, mem_addr_w[k], ea);
        chk({t, " mem_we"}, mem_we_w[k], ewe);
        if (ewe) chk({t, " mem_wdata"}, mem_wdata_w[k], ed);
        chk({t, " early ack"}, {ack_a_w[k], ack_b_w[k]}, 0);
      end else begin
        chk({t, " state"}, st_w[k], ST_DONE);
        chk({t, " ack_a"}, ack_a_w[k], !w);
        chk({t, " ack_b"}, ack_b_w[k], w);
        chk({t, " done mem_we"}, mem_we_w[k], 0);
        if (!ewe) chk({t, " rdata"}, rdata_w[k], er);
      end
    end
    last_srv[k] = w;
    exp_sel[k]  = w;
    if (ewe) ref_mem[key_of(k, ea)] = ed;
    @(posedge clk);
    #1;
    if (keep) set_req(k, w);
    else if (!w) req_a_v[k] = 1'b0;
    else         req_b_v[k] = 1'b0;
    @(negedge clk);
    t = $sformatf("i%0d t%0d gap", k, cyc);
    chk({t, " state"}, st_w[k], ST_IDLE);
    chk({t, " ack"}, {ack_a_w[k], ack_b_w[k]}, 0);
    chk({t, " sel"}, sel_w[k], w);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned b0, prev;
    for (int k = 0; k < NI; k++) begin
      req_a_v[k] = 0; req_b_v[k] = 0; we_a_v[k] = 0; we_b_v[k] = 0;
      addr_a_v[k] = '0; addr_b_v[k] = '0; wdata_a_v[k] = '0; wdata_b_v[k] = '0;
    end
    do_reset();

    // Single read from A, LATENCY = 2
    ram[key_of(1, 15'h0010)]     = 16'h1234;
    ref_mem[key_of(1, 15'h0010)] = 16'h1234;
    b0 = n_ack_b[1];
    req_a_v[1] = 1; addr_a_v[1] = 15'h0010; we_a_v[1] = 0; wdata_a_v[1] = 16'h0;
    serve(1, 0);
    chk("i1 read rdata direct", rdata_w[1], 16'h1234);
    chk("i1 no ack_b", n_ack_b[1] - b0, 0);

    // Write from B, then read it back through A
    req_b_v[1] = 1; addr_b_v[1] = 15'h4000; we_b_v[1] = 1; wdata_b_v[1] = 16'hBEEF;
    serve(1, 0);
    chk("i1 ram 4000", ram_rd(1, 15'h4000), 16'hBEEF);
    req_a_v[1] = 1; addr_a_v[1] = 15'h4000; we_a_v[1] = 0;
    serve(1, 0);

    // Continuous contention after reset: A, B, A, B
    do_reset();
    set_req(1, 0); set_req(1, 1);
    for (int i = 0; i < 4; i++) serve(1, 1'b1);
    serve(1, 0);
    serve(1, 0);

    // Back-to-back A only: ack spacing LATENCY+2
    set_req(1, 0);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      serve(1, i < 3);
      if (i > 0) chk($sformatf("i1 ack spacing %0d", i), ack_cyc[1] - prev, 4);
      prev = ack_cyc[1];
    end

    // Reset in the 2nd ACCESS cycle, LATENCY = 3
    b0 = n_ack_a[2];
    req_a_v[2] = 1; addr_a_v[2] = 15'h7FF0; we_a_v[2] = 1; wdata_a_v[2] = 16'hDEAD;
    @(posedge clk); @(negedge clk);
    chk("i2 abort c1 state", st_w[2], ST_ACCESS);
    chk("i2 abort c1 mem_we", mem_we_w[2], 1);
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("i2 abort c2 state", st_w[2], ST_ACCESS);
    @(posedge clk); @(negedge clk);
    chk("i2 abort state", st_w[2], ST_IDLE);
    chk("i2 abort mem_we", mem_we_w[2], 0);
    chk("i2 abort ack", {ack_a_w[2], ack_b_w[2]}, 0);
    reset = 0;
    for (int k = 0; k < NI; k++) begin
      req_a_v[k] = 0; req_b_v[k] = 0; last_srv[k] = 1; exp_sel[k] = 0;
    end
    repeat (3) idle_check(2);
    chk("i2 abort never acked", n_ack_a[2] - b0, 0);
    set_req(2, 0); set_req(2, 1);
    serve(2, 0);
    serve(2, 0);

    // LATENCY = 1 corner
    set_req(0, 0); we_a_v[0] = 0;
    serve(0, 0);
    chk("i0 single ack", n_ack_a[0], 1);

    // Randomized traffic on every instance
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 14; i++) begin
        int pat;
        pat = $urandom_range(0, 3);
        if (pat[0] && !req_a_v[k]) set_req(k, 0);
        if (pat[1] && !req_b_v[k]) set_req(k, 1);
        if (req_a_v[k] || req_b_v[k]) serve(k, 0);
        else idle_check(k);
      end
      while (req_a_v[k] || req_b_v[k]) serve(k, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester, round-robin arbiter for the single shared RAM port of the Hack computer.
- Requester A is the CPU data port; requester B is the screen/UART DMA engine.
- Sequences each access with a fixed memory latency and drives the address/data multiplexer select for the RAM port.
- Returns read data and a one-cycle acknowledge to the winning requester.

Parameters:
- LATENCY, 1, number of cycles the RAM port is held per access (valid range 1..15).
- AW, 15, address width in bits.
- DW, 16, data word width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_a  input  1  access request from requester A; held high until ack_a.
- addr_a  input  AW  address from A.
- we_a  input  1  write enable from A (1 = write, 0 = read).
- wdata_a  input  DW  write data from A.
- ack_a  output  1  one-cycle access-complete pulse to A.
- req_b, addr_b, we_b, wdata_b, ack_b  same as the A ports, for requester B.
- rdata  output  DW  read data, valid in the cycle ack_a or ack_b is high.
- sel  output  1  RAM-port mux select (0 = A, 1 = B).
- mem_addr  output  AW  RAM address.
- mem_we  output  1  RAM write strobe.
- mem_wdata  output  DW  RAM write data.
- mem_rdata  input  DW  RAM read data, valid LATENCY cycles after mem_addr is applied.

Behaviour:
- FSM states: IDLE, ACCESS, DONE. All state and outputs are registered or decoded from registered state.
- Reset (synchronous, any state, including mid-ACCESS):
  - state = IDLE, cnt = 0, last = 1 (so B counts as last served and A wins the first tie).
  - ack_a = ack_b = 0, mem_we = 0, sel = 0, rdata = 0.
  - An access aborted by reset is never acknowledged.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester not equal to last.
  - On grant: latch sel = winner, cnt = LATENCY-1, go to ACCESS.
- ACCESS:
  - mem_addr / mem_wdata / mem_we come from the granted requester through the sel mux.
  - mem_we = we of the granted requester for every ACCESS cycle.
  - cnt decrements each cycle. When cnt == 0: capture mem_rdata into rdata, go to DONE.
  - Changes in requester inputs during ACCESS are a protocol violation; behaviour is undefined.
- DONE:
  - ack of the granted requester = 1 for exactly this cycle; the other ack stays 0.
  - mem_we = 0. last = sel. Next state is IDLE.
  - rdata is held until the next capture. For writes, rdata carries the mem_rdata captured during the write and is don't-care for requesters.
- Turnaround: IDLE is a mandatory one-cycle gap between transactions.
  - The requester deasserts req at the edge where it samples ack = 1, so the arbiter sees req low in IDLE.
- Latency: req high in cycle 0 (IDLE) gives ACCESS in cycles 1..LATENCY and ack in cycle LATENCY+1.
- Throughput: one access per LATENCY+2 cycles.
- Fairness: under continuous two-sided contention grants strictly alternate. Worst-case wait is one foreign transaction.
- A requester that drops req in IDLE before being granted is simply not served.
- sel holds its value while IDLE (no glitching to 0).
- cnt width: 4 bits.

Decomposition:
- Shared header bus_defs.vh holds:
  - state encodings ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_DONE = 2'd2.
  - AW and DW defaults.
- Sub-module rr_pick2 (combinational):
  - Inputs req_a, req_b, last.
  - Outputs grant_valid, grant_sel.
- RAM-port datapath select uses the existing Mux16 cell for data and a 15-bit mux for address, both driven by sel.

Test Plan:
- Single read: with LATENCY=2, req_a=1, addr_a=0x0010, mem_rdata model returns 0x1234 -> sel=0; mem_addr=0x0010 for 2 cycles; ack_a pulses exactly 3 cycles after req; rdata=0x1234; ack_b never asserts.
- Write from B: req_b=1, we_b=1, addr_b=0x4000, wdata_b=0xBEEF -> mem_we=1 for exactly LATENCY cycles with mem_wdata=0xBEEF; ack_b is one cycle; the RAM model holds 0xBEEF at 0x4000.
- Simultaneous requests after reset: req_a = req_b = 1 continuously -> grants in order A, B, A, B; each ack is a single cycle; one IDLE cycle between transactions.
- Reset mid-ACCESS: assert reset in the 2nd ACCESS cycle with LATENCY=3 -> next cycle: IDLE, mem_we=0, no ack; a subsequent tie is granted to A.
- Back-to-back same requester: only req_a active for 4 transactions -> 4 acks spaced LATENCY+2 cycles apart; sel stays 0 throughout.
- LATENCY=1 corner: read from A -> ack 2 cycles after req; rdata equals mem_rdata sampled during the single ACCESS cycle.
